// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the MULTU sequencer.
//   mul_state_t : sequencer state encoding (IDLE, RUN, DONE)
//   MUL_WIDTH   : default operand width for the HI/LO multiply unit
package cpu_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/multu_shift_add.sv
// Shift-add datapath for the unsigned multiply.
// Holds the accumulator, the left-shifting multiplicand and the
// right-shifting multiplier. The sequencer drives load/step and takes
// the product from o_acc_next on the final step.
//   i_clk, i_rst      : clock, async active-high reset
//   i_load            : capture operands, clear accumulator
//   i_step            : perform one shift-add iteration
//   i_op_a, i_op_b    : multiplicand / multiplier
//   o_acc_next        : accumulator value after the current iteration
module multu_shift_add
    import cpu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    output logic [2*WIDTH-1:0] o_acc_next
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    // The 2*WIDTH accumulator never overflows: the product of two
    // WIDTH-bit unsigned values fits in 2*WIDTH bits.
    assign o_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_op_a};
            r_mplier <= i_op_b;
        end else if (i_step) begin
            r_acc    <= o_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/multu_sequencer.sv
// MULTU controller for the EX stage: runs a WIDTH-cycle shift-add
// multiply, owns HI/LO, and stalls the pipeline on MULTU/MFHI/MFLO
// hazards while a multiply is in flight.
//   i_clk, i_rst       : clock, async active-high reset
//   i_start            : MULTU request
//   i_op_a, i_op_b     : operands (sampled only on acceptance)
//   i_rd_hi, i_rd_lo   : MFHI / MFLO in EX
//   i_flush            : abort in-flight multiply
//   o_hi, o_lo         : HI / LO registers
//   o_busy             : multiply in progress
//   o_done             : one-cycle pulse, HI/LO just updated
//   o_stall            : freeze IF/ID/EX (combinational)
//
// state | meaning
// IDLE  | no multiply; HI/LO readable, start accepted
// RUN   | shift-add iterating; start/MFHI/MFLO stall
// DONE  | HI/LO just written; start accepted as in IDLE
module multu_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_rd_hi,
    input  logic             i_rd_lo,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stall
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_t         r_state;
    mul_state_t         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_load;
    logic               w_step;
    logic               w_wr_hilo;
    logic [2*WIDTH-1:0] w_acc_next;

    multu_shift_add #(.WIDTH(WIDTH)) u_shift_add (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .o_acc_next (w_acc_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_wr_hilo    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                // Flush wins over start so a squashed MULTU never launches.
                if (i_start && !i_flush) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (i_flush) begin
                    w_state_next = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_wr_hilo    = 1'b1;
                        w_state_next = DONE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            o_hi  <= '0;
            o_lo  <= '0;
        end else begin
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_wr_hilo) begin
                o_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                o_lo <= w_acc_next[WIDTH-1:0];
            end
        end
    end

    assign o_busy  = (r_state == RUN);
    assign o_done  = (r_state == DONE);
    // Start is not latched while busy; the frozen pipeline re-presents
    // it and it is picked up in DONE.
    assign o_stall = o_busy & (i_start | i_rd_hi | i_rd_lo);

endmodule

// File: tb/tb_multu_sequencer.sv
module tb_multu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        rd_hi;
    logic        rd_lo;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    multu_sequencer #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_op_a  (op_a),
        .i_op_b  (op_b),
        .i_rd_hi (rd_hi),
        .i_rd_lo (rd_lo),
        .i_flush (flush),
        .o_hi    (hi),
        .o_lo    (lo),
        .o_busy  (busy),
        .o_done  (done),
        .o_stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one multiply and wait (bounded) for done. lat counts the
    // cycles from acceptance until done is seen; nbusy counts busy cycles.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nbusy);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        lat   = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            op_a  = ~a;
            op_b  = ~b;
            lat++;
            if (busy) nbusy++;
        end while (!done && lat < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nbusy;
        int nstall;
        int ndone;

        vecs[0] = '{32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[4] = '{32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{32'hDEAD_BEEF, 32'd1,         32'h0000_0000, 32'hDEAD_BEEF};

        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        rd_hi = 1'b0;
        rd_lo = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy_done", {busy, done}, 64'd0);
        rd_hi = 1'b1;
        start = 1'b1;
        #1;
        check("reset_stall", 64'(stall), 64'd0);
        rd_hi = 1'b0;
        start = 1'b0;
        rst   = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_mul(vecs[i].a, vecs[i].b, lat, nbusy);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_busy_cycles", i), 64'(nbusy), 64'd32);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {busy, done}, 64'd0);
        end

        // MFHI hazard: hold rd_hi from the first RUN cycle.
        @(negedge clk);
        op_a  = 32'd7;
        op_b  = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        rd_hi  = 1'b1;
        nstall = 0;
        lat    = 1;
        #1;
        while (busy && lat < 40) begin
            if (stall) nstall++;
            @(negedge clk);
            lat++;
            #1;
        end
        check("mfhi_stall_cycles", 64'(nstall), 64'd32);
        check("mfhi_done_stall", {done, stall}, 64'b10);
        check("mfhi_hi", 64'(hi), 64'd0);
        check("mfhi_lo", 64'(lo), 64'd63);
        rd_hi = 1'b0;
        @(negedge clk);

        // Back-to-back: second MULTU held during RUN, accepted in DONE.
        op_a  = 32'd2;
        op_b  = 32'd3;
        start = 1'b1;
        @(negedge clk);
        op_a   = 32'd4;
        op_b   = 32'd5;
        nstall = 0;
        lat    = 1;
        #1;
        while (!done && lat < 40) begin
            if (stall) nstall++;
            @(negedge clk);
            lat++;
            #1;
        end
        check("b2b_stall_cycles", 64'(nstall), 64'd32);
        check("b2b_first_lat", 64'(lat), 64'd33);
        check("b2b_first_lo", 64'(lo), 64'd6);
        check("b2b_done_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted_in_done", 64'(busy), 64'd1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_gap", 64'(lat), 64'd33);
        check("b2b_second_lo", 64'(lo), 64'd20);
        check("b2b_second_hi", 64'(hi), 64'd0);

        // Flush mid-op after a 3*5 result.
        do_mul(32'd3, 32'd5, lat, nbusy);
        check("pre_flush_lo", 64'(lo), 64'd15);
        @(negedge clk);
        op_a  = 32'd100;
        op_b  = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {busy, done}, 64'd0);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("flush_no_done", 64'(ndone), 64'd0);
        check("flush_hi", 64'(hi), 64'd0);
        check("flush_lo", 64'(lo), 64'd15);
        start = 1'b1;
        flush = 1'b1;
        op_a  = 32'd6;
        op_b  = 32'd6;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_beats_start", {busy, done}, 64'd0);
        repeat (35) @(negedge clk);
        check("flush_start_lo", 64'(lo), 64'd15);

        // Asynchronous reset in RUN cycle 20.
        op_a  = 32'd100;
        op_b  = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b1;
        rd_lo = 1'b1;
        repeat (19) @(negedge clk);
        check("rst_busy_before", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_busy_done", {busy, done}, 64'd0);
        check("rst_async_stall", 64'(stall), 64'd0);
        check("rst_async_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        rd_lo = 1'b0;
        rst   = 1'b0;
        do_mul(32'd3, 32'd5, lat, nbusy);
        check("post_rst_latency", 64'(lat), 64'd33);
        check("post_rst_result", {hi, lo}, 64'h0000_0000_0000_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multu_sequencer.md
Name: multu_sequencer

Overview:
Multi-cycle controller and datapath for MULTU in the pipelined CPU's EX stage. It accepts the MULTU request decoded by ALU control and runs an unsigned shift-add multiply over WIDTH cycles. It owns the HI/LO registers and stalls the pipeline whenever a new MULTU, MFHI or MFLO arrives while a multiply is in flight. Results go to the EX-stage HI/LO read mux.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  MULTU request from ALU control (SignaltoMULTU), EX stage.
op_a  in  WIDTH  multiplicand (rs value).
op_b  in  WIDTH  multiplier (rt value).
rd_hi  in  1  MFHI in EX (SignaltoHi).
rd_lo  in  1  MFLO in EX (SignaltoLo).
flush  in  1  pipeline flush; aborts an in-flight multiply.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
busy  out  1  multiply in progress (state RUN).
done  out  1  one-cycle pulse: HI/LO just updated.
stall  out  1  freeze IF/ID/EX; combinational.

Behaviour:
- Reset (async, active-high): state=IDLE; hi=0, lo=0, done=0, counter=0, internal accumulator, shifted multiplicand and multiplier regs=0. Reset mid-RUN discards the operation.
- States: IDLE, RUN, DONE. busy=1 only in RUN.
- IDLE/DONE, start=1 and flush=0: latch mcand={WIDTH'0,op_a}, mplier=op_b, acc=0, cnt=0; go to RUN. DONE accepts start exactly as IDLE does, so back-to-back MULTU adds no bubble.
- IDLE/DONE, start=0 or flush=1: go to IDLE. Flush beats start.
- RUN, each cycle:
  - acc_next = acc + (mplier[0] ? mcand : 0), computed 2*WIDTH wide with no overflow.
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt==WIDTH-1, the cycle is the last iteration: {hi,lo} <= acc_next; go to DONE.
- RUN with flush=1: go to IDLE on that edge; hi/lo unchanged; no done pulse.
- Latency: start sampled at edge 0; WIDTH RUN cycles follow. hi/lo show the product and done=1 in cycle WIDTH+1. Latency is fixed; there is no early termination for zero operands.
- done=1 only in DONE, for exactly one cycle.
- stall = busy & (start | rd_hi | rd_lo). In RUN, start is not latched; the stalled pipeline re-presents it until it is accepted in DONE.
- MFHI/MFLO stall until the cycle after the last RUN cycle. They then read the new HI/LO.
- rd_hi/rd_lo in IDLE or DONE: no stall; hi/lo read directly.
- hi/lo change only on the final RUN iteration or on reset.
- op_a/op_b are sampled only at acceptance. Changes during RUN are ignored.

Decomposition:
- Shared package cpu_pkg:
  - state enum {IDLE, RUN, DONE} as a 2-bit typedef mul_state_t.
  - MUL_WIDTH=32 constant, the default for WIDTH.
- One natural sub-module: multu_shift_add.
  - Contains the acc/mcand/mplier registers and the adder.
  - Inputs: load, step.
  - Output: acc_next.
- multu_sequencer keeps the FSM, counter, HI/LO registers and stall logic.

Test Plan:
- Basic multiply: reset, then start with op_a=3, op_b=5 for one cycle. Required: busy=1 for 32 cycles; done=1 in cycle 33; hi=0x00000000, lo=0x0000000F.
- Max operands: op_a=op_b=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001. Then op_a=0x80000000, op_b=2. Required: hi=1, lo=0.
- MFHI hazard: start 7*9, then hold rd_hi=1 from the next cycle. Required: stall=1 for the remaining RUN cycles; stall=0 in DONE, where hi=0 and lo=63 are visible.
- Back-to-back: start 2*3, hold start (4*5) during RUN. Required: stall=1 throughout RUN; the second multiply is accepted in DONE; lo=6, then lo=20 exactly 33 cycles later.
- Flush mid-op: after a prior result hi=0, lo=15, start 100*100 and assert flush at RUN cycle 10. Required: IDLE next cycle, busy=0, no done, hi/lo stay 0/15. Flush+start in IDLE: not accepted.
- Reset mid-op: assert rst at RUN cycle 20. Required: immediate (asynchronous) state=IDLE, hi=lo=0, done=0, stall=0. After release, a new 3*5 completes normally.
